// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the program-counter sequencer: next-PC select
// encodings and the default datapath width.
package pc_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_INC = 2'b00;
    localparam sel_t SEL_JR  = 2'b01;
    localparam sel_t SEL_BR  = 2'b10;
    localparam sel_t SEL_RET = 2'b11;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the FSM/register bank (master) and the
// program-counter sequencer (slave).
interface pc_sequencer_if #(
    parameter int WIDTH = pc_seq_pkg::DEFAULT_WIDTH
);

    logic             stall;
    logic [1:0]       select;
    logic             call;
    logic [WIDTH-1:0] sr1_out;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] pc;
    logic             pc_valid;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;
    logic             ras_underflow;

    modport master (
        output stall, select, call, sr1_out, offset,
        input  pc, pc_valid, ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, select, call, sr1_out, offset,
        output pc, pc_valid, ras_empty, ras_full, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack: pushes past capacity overwrite the oldest
// entry, pops of an empty stack raise a one-cycle underflow pulse.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [PTR_W-1:0] topPtr;
    logic [PTR_W-1:0] nextPtr;

    // wrPtr_q names the next free slot, so the top lives one slot behind it
    assign topPtr  = (wrPtr_q == '0) ? LAST_PTR : wrPtr_q - 1'b1;
    assign nextPtr = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign top       = mem_q[topPtr];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        wrPtr_d     = wrPtr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (push) begin
            wrPtr_d = nextPtr;
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (pop) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                wrPtr_d = topPtr;
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with increment / jump-register / PC-relative
// branch / return selection, stall hold and a call/return address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = DEFAULT_WIDTH,
    parameter int               RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic           clock,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pcValid_q;
    logic [WIDTH-1:0] pcPlusOne;
    logic [WIDTH-1:0] branchTarget;
    logic [WIDTH-1:0] rasTop;
    logic             rasEmpty;
    logic             rasPush;
    logic             rasPop;

    // Wrap-around adders; the offset is two's complement so a plain add works
    assign pcPlusOne    = pc_q + WIDTH'(1);
    assign branchTarget = pc_q + bus.offset;

    assign rasPush = !bus.stall && bus.call &&
                     (bus.select == SEL_JR || bus.select == SEL_BR);
    assign rasPop  = !bus.stall && (bus.select == SEL_RET);

    always_comb begin
        pc_d = pc_q;
        if (!bus.stall) begin
            unique case (bus.select)
                SEL_INC: pc_d = pcPlusOne;
                SEL_JR:  pc_d = bus.sr1_out;
                SEL_BR:  pc_d = branchTarget;
                SEL_RET: pc_d = rasEmpty ? pcPlusOne : rasTop;
                default: pc_d = pcPlusOne;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_VECTOR;
            pcValid_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pcValid_q <= 1'b1;
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (rasPush),
        .pop       (rasPop),
        .din       (pcPlusOne),
        .top       (rasTop),
        .empty     (rasEmpty),
        .full      (bus.ras_full),
        .overflow  (bus.ras_overflow),
        .underflow (bus.ras_underflow)
    );

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = pcValid_q;
    assign bus.ras_empty = rasEmpty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized check of pc_sequencer against a queue-based
// reference model of the PC and return-address stack.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int          WIDTH = 16;
    localparam int          DEPTH = 4;
    localparam logic [15:0] RV    = 16'h0100;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    // reference model state
    logic [15:0] modelPc;
    logic        modelValid;
    logic [15:0] modelRas[$];
    logic        expOverflow;
    logic        expUnderflow;

    pc_sequencer_if #(.WIDTH(WIDTH)) bus ();

    pc_sequencer #(
        .WIDTH        (WIDTH),
        .RAS_DEPTH    (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("pc", bus.pc, modelPc);
        checkValue("pc_valid", 16'(bus.pc_valid), 16'(modelValid));
        checkValue("ras_empty", 16'(bus.ras_empty), 16'(modelRas.size() == 0));
        checkValue("ras_full", 16'(bus.ras_full), 16'(modelRas.size() == DEPTH));
        checkValue("ras_overflow", 16'(bus.ras_overflow), 16'(expOverflow));
        checkValue("ras_underflow", 16'(bus.ras_underflow), 16'(expUnderflow));
    endtask

    // Drive one cycle of controls, advance the model, clock, then compare
    task automatic applyStimulus(input logic rst, input logic stl, input logic [1:0] sel,
                                 input logic cl, input logic [15:0] sr1, input logic [15:0] off);
        logic [15:0] retAddr;
        reset       = rst;
        bus.stall   = stl;
        bus.select  = sel;
        bus.call    = cl;
        bus.sr1_out = sr1;
        bus.offset  = off;
        retAddr     = modelPc + 16'd1;
        expOverflow  = 1'b0;
        expUnderflow = 1'b0;
        if (rst) begin
            modelPc    = RV;
            modelValid = 1'b0;
            modelRas.delete();
        end else begin
            modelValid = 1'b1;
            if (!stl) begin
                if (cl && (sel == SEL_JR || sel == SEL_BR)) begin
                    if (modelRas.size() == DEPTH) begin
                        void'(modelRas.pop_front());
                        expOverflow = 1'b1;
                    end
                    modelRas.push_back(retAddr);
                end
                case (sel)
                    SEL_INC: modelPc = retAddr;
                    SEL_JR:  modelPc = sr1;
                    SEL_BR:  modelPc = modelPc + off;
                    default: begin
                        if (modelRas.size() == 0) begin
                            modelPc      = retAddr;
                            expUnderflow = 1'b1;
                        end else begin
                            modelPc = modelRas.pop_back();
                        end
                    end
                endcase
            end
        end
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        modelPc      = RV;
        modelValid   = 1'b0;
        expOverflow  = 1'b0;
        expUnderflow = 1'b0;
        reset        = 1'b1;
        bus.stall    = 1'b0;
        bus.select   = SEL_INC;
        bus.call     = 1'b0;
        bus.sr1_out  = '0;
        bus.offset   = '0;
        @(negedge clock);

        // reset then plain increments from the reset vector
        applyStimulus(1, 0, SEL_INC, 0, 16'h0, 16'h0);
        checkValue("reset_pc_const", bus.pc, 16'h0100);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, SEL_INC, 0, 16'h0, 16'h0);
        checkValue("inc3_pc_const", bus.pc, 16'h0103);

        // wrap boundaries
        applyStimulus(0, 0, SEL_JR, 0, 16'hFFFF, 16'h0);
        applyStimulus(0, 0, SEL_INC, 0, 16'h0, 16'h0);
        checkValue("wrap_inc_const", bus.pc, 16'h0000);
        applyStimulus(0, 0, SEL_JR, 0, 16'h0010, 16'h0);
        applyStimulus(0, 0, SEL_BR, 0, 16'h0, 16'hFFF0);
        checkValue("neg_branch_const", bus.pc, 16'h0000);
        applyStimulus(0, 0, SEL_JR, 0, 16'h0010, 16'h0);
        applyStimulus(0, 0, SEL_JR, 0, 16'h1234, 16'h0);

        // single call / return pair
        applyStimulus(0, 0, SEL_JR, 0, 16'h0020, 16'h0);
        applyStimulus(0, 0, SEL_JR, 1, 16'h0400, 16'h0);
        applyStimulus(0, 0, SEL_RET, 0, 16'h0, 16'h0);
        checkValue("return_const", bus.pc, 16'h0021);

        // five nested calls overflow a 4-deep stack, then five returns
        applyStimulus(0, 0, SEL_JR, 0, 16'h0010, 16'h0);
        for (int i = 1; i <= 5; i++) applyStimulus(0, 0, SEL_JR, 1, 16'(16'h0010 + i), 16'h0);
        checkValue("overflow_pulse_const", 16'(bus.ras_overflow), 16'h1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, SEL_RET, 0, 16'h0, 16'h0);
        checkValue("underflow_pulse_const", 16'(bus.ras_underflow), 16'h1);

        // stall holds everything, including a pending call
        applyStimulus(0, 0, SEL_JR, 1, 16'h0200, 16'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, SEL_BR, 1, 16'h0, 16'h0005);

        // reset wins over a simultaneous call
        applyStimulus(1, 0, SEL_JR, 1, 16'h0777, 16'h0);
        applyStimulus(0, 0, SEL_RET, 0, 16'h0, 16'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program-counter unit for the MCU datapath. It replaces the single-shot PC mux and adder with a registered PC and a four-way next-PC select: increment, jump-register, PC-relative branch, and return. It adds a stall hold and a circular return-address stack (RAS) for call/return. It sits between the FSM, which drives select/call/stall, the register bank, which supplies SR1OUT, and instruction memory, which consumes pc.

Parameters:
WIDTH, 16, PC and operand width in bits (>= 4)
RAS_DEPTH, 4, return-address stack entries (>= 2; need not be a power of two)
RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits)

Ports:
clock  input  1  single system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  1 = hold PC and RAS unchanged this cycle; all other controls ignored
select  input  2  next-PC source: 00 inc, 01 jump-reg, 10 branch, 11 return
call  input  1  with select 01 or 10, push pc+1 onto the RAS
sr1_out  input  WIDTH  jump target from the register bank
offset  input  WIDTH  two's-complement branch displacement
pc  output  WIDTH  current program counter, registered
pc_valid  output  1  0 during reset and through the reset cycle; 1 from the first clock edge with reset low
ras_empty  output  1  RAS holds 0 entries
ras_full  output  1  RAS holds RAS_DEPTH entries
ras_overflow  output  1  one-cycle pulse: a push overwrote the oldest entry
ras_underflow  output  1  one-cycle pulse: a return was issued with the RAS empty

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset (sampled at an edge):
  - pc = RESET_VECTOR, pc_valid = 0.
  - RAS count = 0, pointer = 0, ras_empty = 1, ras_full = 0, both pulses = 0.
  - RAS contents are don't-care.
  - Reset has priority over stall and all controls, including mid-call or mid-return.
- Registered outputs: all outputs are registered. pc changes exactly one edge after the controls are sampled, so latency is 1 cycle. There is no combinational path from inputs to outputs.
- Next PC, when not stalled (all arithmetic is modulo 2^WIDTH; no carry out, no saturation):
  - 00: pc + 1. All-ones wraps to 0.
  - 01: sr1_out.
  - 10: pc + offset, with offset sign-interpreted.
  - 11: top of RAS (pop). If the RAS is empty: pc + 1, RAS unchanged, ras_underflow = 1 for one cycle.
- Call:
  - With select 01/10, push (pc + 1) mod 2^WIDTH in the same edge as the PC load.
  - Push when full: overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_overflow = 1 for one cycle.
  - Call with select 00: ignored.
  - Call with select 11: call ignored, return performed. A push and a pop never happen on the same edge.
- RAS storage:
  - Circular buffer with a write pointer and a saturating count 0..RAS_DEPTH.
  - The pointer wraps modulo RAS_DEPTH.
  - ras_empty and ras_full are derived from the registered count.
- Stall: pc, RAS and flags hold; the pulse outputs return to 0. Stall during reset has no effect, because reset wins.
- pc_valid is 1 from the first edge with reset low, and stays 1 until the next reset.

Decomposition:
- Shared package pc_seq_pkg holds:
  - select encodings SEL_INC = 2'b00, SEL_JR = 2'b01, SEL_BR = 2'b10, SEL_RET = 2'b11;
  - the default WIDTH constant.
- One sub-module is natural: ras_stack (parameters WIDTH and RAS_DEPTH).
  - Inputs: push, pop, din.
  - Outputs: top, empty, full, overflow, underflow.
  - Same clock and reset.
- Next-PC adders stay inline in pc_sequencer.

Test Plan:
- Reset then 3 cycles of select 00, with RESET_VECTOR = 0x0100: pc = 0x0100, 0x0101, 0x0102, 0x0103; pc_valid = 0 in the reset cycle, then 1.
- pc = 0xFFFF, select 00 → pc = 0x0000. pc = 0x0010, select 10, offset = 0xFFF0 → pc = 0x0000. pc = 0x0010, select 01, sr1_out = 0x1234 → pc = 0x1234.
- Call at pc = 0x0020 (select 01, sr1_out = 0x0400), then select 11 at 0x0400 → pc = 0x0400, then 0x0021; ras_empty returns to 1.
- RAS_DEPTH = 4, five calls from pcs 0x10..0x14 → ras_overflow pulses on the 5th call. Five returns yield 0x15, 0x14, 0x13, 0x12; the 5th return gives pc + 1 and ras_underflow = 1.
- Stall high 3 cycles with select 10, call = 1 → pc, count and flags unchanged; no pulses.
- Reset asserted mid-sequence with call = 1 → next edge pc = RESET_VECTOR, ras_empty = 1, no push recorded.
